event_stream_encoder: RTL and testbench

- Transmit side of the packed event bus consumed by the event-based denoising filter.
- Accepts sensor events (x, y, polarity) over a valid/ready handshake and timestamps them with a free-running 2-bit tick counter.
- Buffers events in a small FIFO and emits them as paced 8-bit words {p2, t, y, x}: bits [7:6] = 2'b11 for a valid ON event, 2'b00 otherwise.
- Idle and gap cycles drive 8'h00 so the downstream filter's output gate stays closed.

---
 rtl/ev_pkg.sv | 39 +++
 rtl/ev_fifo.sv | 67 ++++++
 rtl/event_stream_encoder.sv | 132 +++++++++++++
 tb/tb_event_stream_encoder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ev_pkg.sv
// Shared types and field layout for the packed 8-bit event word.
// Used by both the transmit encoder and the receive side.
package ev_pkg;

  typedef struct packed {
    logic       p;
    logic [1:0] t;
    logic [1:0] y;
    logic [1:0] x;
  } ev_entry_t;

  localparam int ENTRY_W = $bits(ev_entry_t);

  localparam int X_LSB = 0;
  localparam int Y_LSB = 2;
  localparam int T_LSB = 4;
  localparam int P_LSB = 6;

  localparam logic [1:0] P_ON = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  // OFF events still go out, but with the polarity field cleared so the
  // downstream output gate stays closed for them.
  function automatic logic [7:0] pack_word(ev_entry_t e);
    logic [7:0] w;
    w = '0;
    w[P_LSB +: 2] = e.p ? P_ON : 2'b00;
    w[T_LSB +: 2] = e.t;
    w[Y_LSB +: 2] = e.y;
    w[X_LSB +: 2] = e.x;
    return w;
  endfunction

endpackage

// File: rtl/ev_fifo.sv
// Synchronous FIFO with occupancy-based full/empty detection.
// DEPTH must be a power of two so the pointers wrap naturally.
module ev_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    // NOTE: registers update with <= so every flop samples pre-edge values regardless of statement order.
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is not reset; level_q guards every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/event_stream_encoder.sv
// Timestamps sensor events, buffers them and emits paced 8-bit words
// onto the packed event bus; idle and gap cycles carry 8'h00.
module event_stream_encoder
  import ev_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 8,
  parameter int MIN_GAP    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic [1:0]                    ev_x,
  input  logic [1:0]                    ev_y,
  input  logic                          ev_p,
  output logic [7:0]                    out_word,
  output logic                          out_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W   = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         tick_q, tick_d;
  logic [7:0]         drop_cnt_q, drop_cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         out_word_q, out_word_d;
  logic               out_valid_q, out_valid_d;
  state_t             state_q, state_d;

  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  ev_entry_t          head;

  // No bypass: a pop in the same cycle does not free a slot for the push.
  assign ev_ready   = en && !fifo_full;
  assign fifo_push  = ev_valid && ev_ready;
  assign fifo_wdata = {ev_p, tick_q, ev_y, ev_x};
  assign head       = fifo_rdata;

  assign out_word   = out_word_q;
  assign out_valid  = out_valid_q;
  assign drop_cnt   = drop_cnt_q;

  ev_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Timestamp base runs regardless of en so t stays tied to wall time.
  always_comb begin
    presc_d = presc_q + PRESC_W'(1);
    tick_d  = tick_q;
    if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
      presc_d = '0;
      tick_d  = tick_q + 2'd1;
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ev_valid && en && fifo_full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    out_word_d  = 8'h00;
    out_valid_d = 1'b0;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          fifo_pop    = 1'b1;
          out_word_d  = pack_word(head);
          out_valid_d = 1'b1;
          state_d     = SEND;
        end
      end
      SEND: begin
        gap_d   = GAP_W'(MIN_GAP - 1);
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      presc_q     <= '0;
      tick_q      <= '0;
      drop_cnt_q  <= '0;
      gap_q       <= '0;
      out_word_q  <= 8'h00;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
    end else begin
      presc_q     <= presc_d;
      tick_q      <= tick_d;
      drop_cnt_q  <= drop_cnt_d;
      gap_q       <= gap_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_event_stream_encoder.sv
// Self-checking bench: randomized stimulus against a queue-based model of the
// event stream, plus hand-computed expectations for the directed scenarios.
module tb_event_stream_encoder;

  localparam int DEPTH = 4;
  localparam int TDIV  = 8;
  localparam int GAP   = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ev_valid = 1'b0;
  logic [1:0] ev_x = 2'd0;
  logic [1:0] ev_y = 2'd0;
  logic       ev_p = 1'b0;
  logic       ev_ready;
  logic [7:0] out_word;
  logic       out_valid;
  logic [2:0] fifo_level;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  event_stream_encoder #(
    .FIFO_DEPTH (DEPTH),
    .TICK_DIV   (TDIV),
    .MIN_GAP    (GAP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_x       (ev_x),
    .ev_y       (ev_y),
    .ev_p       (ev_p),
    .out_word   (out_word),
    .out_valid  (out_valid),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Behavioural model: a queue of accepted events, the wall-clock edge count
  // (which fixes the timestamp) and the edge of the last emitted word.
  logic [6:0] q[$];
  int         edge_cnt  = 0;
  int         last_emit = -100;
  logic [7:0] m_word    = 8'h00;
  logic       m_valid   = 1'b0;
  logic [7:0] m_drop    = 8'h00;

  always @(posedge clk or posedge rst_n) begin
    bit         full, do_pop, do_push;
    logic [1:0] t;
    logic [6:0] head;
    if (rst_n) begin
      q.delete();
      edge_cnt  = 0;
      last_emit = -100;
      m_word    = 8'h00;
      m_valid   = 1'b0;
      m_drop    = 8'h00;
    end else begin
      full    = (q.size() == DEPTH);
      do_pop  = en && (q.size() != 0) && (edge_cnt >= last_emit + 2 + GAP);
      do_push = ev_valid && en && !full;
      t       = 2'((edge_cnt / TDIV) % 4);
      if (ev_valid && en && full && m_drop != 8'd255) m_drop++;
      if (do_pop) begin
        head      = q.pop_front();
        m_word    = {(head[6] ? 2'b11 : 2'b00), head[5:0]};
        m_valid   = 1'b1;
        last_emit = edge_cnt;
      end else begin
        m_word  = 8'h00;
        m_valid = 1'b0;
      end
      if (do_push) q.push_back({ev_p, t, ev_y, ev_x});
      edge_cnt++;
    end
  end

  always @(negedge clk) begin
    check("ev_ready",   32'(ev_ready),   32'(en && (q.size() < DEPTH)));
    check("out_word",   32'(out_word),   32'(m_word));
    check("out_valid",  32'(out_valid),  32'(m_valid));
    check("fifo_level", 32'(fifo_level), 32'(q.size()));
    check("drop_cnt",   32'(drop_cnt),   32'(m_drop));
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_rand();
    ev_valid = 1'b1;
    ev_x     = 2'($urandom);
    ev_y     = 2'($urandom);
    ev_p     = 1'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    ev_valid = 1'b0;
    en       = 1'b1;
    guard    = 0;
    while (!(q.size() == 0 && edge_cnt >= last_emit + 2 + GAP + 2) && guard < 60) begin
      step();
      guard++;
    end
    if (guard == 60) timeout("wait_idle");
  endtask

  task automatic wait_tick(input int tk);
    int guard;
    guard = 0;
    while (((edge_cnt / TDIV) % 4) != tk && guard < 40) begin
      step();
      guard++;
    end
    if (guard == 40) timeout("wait_tick");
  endtask

  initial begin
    int   maxl;
    bit   saw_nr;
    int   emits[$];
    logic [1:0] tf[$];
    bit   saw_wrap;
    int   cnt;
    logic [7:0] base;

    #1 rst_n = 1'b1;
    #1;
    check("rst_word",  32'(out_word),   32'h00);
    check("rst_valid", 32'(out_valid),  32'h0);
    check("rst_level", 32'(fifo_level), 32'h0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;

    // Single ON event at t=2: x=1 y=2 p=1 -> 8'hE9
    wait_idle();
    wait_tick(2);
    ev_valid = 1'b1; ev_x = 2'd1; ev_y = 2'd2; ev_p = 1'b1;
    step();
    ev_valid = 1'b0;
    check("single_pre_valid", 32'(out_valid), 32'h0);
    step();
    check("single_word",  32'(out_word),  32'hE9);
    check("single_valid", 32'(out_valid), 32'h1);
    step();
    check("single_after_word",  32'(out_word),  32'h00);
    check("single_after_valid", 32'(out_valid), 32'h0);

    // OFF event at t=0: x=3 y=0 p=0 -> 8'h03
    wait_idle();
    wait_tick(0);
    ev_valid = 1'b1; ev_x = 2'd3; ev_y = 2'd0; ev_p = 1'b0;
    step();
    ev_valid = 1'b0;
    step();
    check("off_word",  32'(out_word),  32'h03);
    check("off_valid", 32'(out_valid), 32'h1);

    // Overflow: 10 back-to-back requests -> 7 accepted, 3 refused
    wait_idle();
    base   = m_drop;
    maxl   = 0;
    saw_nr = 1'b0;
    emits.delete();
    for (int i = 0; i < 22; i++) begin
      if (i < 10) drive_rand();
      else        ev_valid = 1'b0;
      step();
      if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
      if (!ev_ready) saw_nr = 1'b1;
      if (out_valid) emits.push_back(edge_cnt);
    end
    check("ovf_max_level", 32'(maxl), 32'd4);
    check("ovf_not_ready", 32'(saw_nr), 32'd1);
    check("ovf_drops",     32'(drop_cnt), 32'(base + 8'd3));
    check("ovf_emits",     32'(emits.size()), 32'd7);
    for (int i = 1; i < emits.size(); i++) begin
      check("ovf_pacing", 32'(emits[i] - emits[i-1]), 32'd3);
    end

    // Pacing and timestamp wrap: 8 events spaced 5 cycles apart
    wait_idle();
    tf.delete();
    for (int i = 0; i < 8; i++) begin
      drive_rand();
      step();
      ev_valid = 1'b0;
      if (out_valid) tf.push_back(out_word[5:4]);
      for (int j = 0; j < 4; j++) begin
        step();
        if (out_valid) tf.push_back(out_word[5:4]);
      end
    end
    for (int j = 0; j < 8; j++) begin
      step();
      if (out_valid) tf.push_back(out_word[5:4]);
    end
    saw_wrap = 1'b0;
    for (int i = 1; i < tf.size(); i++) begin
      if (tf[i-1] == 2'd3 && tf[i] == 2'd0) saw_wrap = 1'b1;
    end
    check("pace_count", 32'(tf.size()), 32'd8);
    check("pace_wrap",  32'(saw_wrap),  32'd1);

    // Enable gating: drop en while the second word is in SEND
    wait_idle();
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      step();
    end
    ev_valid = 1'b0;
    begin
      int guard;
      guard = 0;
      while (!out_valid && guard < 20) begin
        step();
        guard++;
      end
      if (guard == 20) timeout("en_wait_send");
    end
    en  = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid) cnt++;
    end
    check("en_gated_words", 32'(cnt), 32'd0);
    check("en_gated_level", 32'(fifo_level), 32'd2);
    check("en_gated_ready", 32'(ev_ready), 32'd0);
    en = 1'b1;
    step();
    check("en_resume_valid", 32'(out_valid), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      ev_valid = ($urandom_range(0, 9) < 6);
      ev_x     = 2'($urandom);
      ev_y     = 2'($urandom);
      ev_p     = 1'($urandom);
      step();
    end

    // Reset mid-stream with entries queued
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      step();
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("mid_rst_word",  32'(out_word),   32'h00);
    check("mid_rst_valid", 32'(out_valid),  32'h0);
    check("mid_rst_level", 32'(fifo_level), 32'h0);
    check("mid_rst_drop",  32'(drop_cnt),   32'h0);
    ev_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    en    = 1'b1;
    #1;
    check("post_rst_ready", 32'(ev_ready), 32'h1);
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
